// File: rtl/iir_coef_ctrl.sv
// iir_coef_ctrl -- coefficient bank controller for one iir_core instance.
//
// Keeps two banks of N = (ORDER+1)*2 signed fixed-point coefficients. The
// shadow bank is written one word at a time from the config port. The active
// bank drives the core's coefs input. On commit the controller blocks the
// input stream and waits until every sample already inside the core has left
// through its output handshake. It then copies shadow into active in a single
// cycle, so no sample ever sees a mix of old and new coefficients.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   s_axis_*           upstream sample stream (tdata, tvalid, tready)
//   core_s_*           stream into iir_core (tdata, tvalid out; tready in)
//   core_m_tvalid/rdy  tap of the core's output handshake (inputs only)
//   coefs              active bank, index 0 in the least significant word
//   wr_en/addr/data    shadow bank write port; writes to addr >= N are dropped
//   rd_addr/rd_data    combinational readback of the active bank; 0 when out of range
//   commit             single-cycle request to make the shadow bank live
//   busy               high while draining or swapping
//   commit_done        one-cycle pulse in the first cycle the new bank is live
module iir_coef_ctrl #(
  parameter int  DW    = 24,
  parameter int  COEFW = 18,
  parameter int  COEFQ = 16,
  parameter int  ORDER = 2,
  localparam int N     = (ORDER + 1) * 2,
  localparam int AW    = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DW-1:0]           core_s_tdata,
  output logic                    core_s_tvalid,
  input  logic                    core_s_tready,
  input  logic                    core_m_tvalid,
  input  logic                    core_m_tready,
  output logic [N-1:0][COEFW-1:0] coefs,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [COEFW-1:0]        wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic [COEFW-1:0]        rd_data,
  input  logic                    commit,
  output logic                    busy,
  output logic                    commit_done
);

  // Identity filter: unity gain on tap 0, every other tap zero.
  localparam logic [COEFW-1:0]          ONE   = COEFW'(1) << COEFQ;
  localparam logic [N-1:0][COEFW-1:0]   IDENT = {{((N - 1) * COEFW){1'b0}}, ONE};
  // N widened by one bit so "addr < N" works even when N is a power of two.
  localparam logic [AW:0]               NW    = (AW + 1)'(N);

  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

  state_t                  state;
  logic [2:0]              outstanding;
  logic [2:0]              cnt_nxt;
  logic                    in_hs;
  logic                    out_hs;
  logic [N-1:0][COEFW-1:0] shadow;
  logic [N-1:0][COEFW-1:0] active;

  // Upstream passes straight through in RUN. Outside RUN both valid toward the
  // core and ready toward the source are forced low, so nothing is accepted.
  assign core_s_tdata  = s_axis_tdata;
  assign core_s_tvalid = (state == RUN) && s_axis_tvalid;
  assign s_axis_tready = (state == RUN) && core_s_tready;
  assign busy          = (state != RUN);
  assign coefs         = active;

  assign in_hs  = core_s_tvalid && core_s_tready;
  assign out_hs = core_m_tvalid && core_m_tready;

  // Samples inside the core after this edge. DRAIN uses this next value so the
  // swap is not held back one cycle by a sample that leaves in the current cycle.
  always_comb begin
    cnt_nxt = outstanding + 3'(in_hs) - 3'(out_hs);
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < NW) rd_data = active[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      outstanding <= '0;
      commit_done <= 1'b0;
      shadow      <= IDENT;
      active      <= IDENT;
    end else begin
      outstanding <= cnt_nxt;
      commit_done <= 1'b0;
      // A write in the SWAP cycle lands in shadow only. Active takes the
      // pre-write shadow contents because both updates happen at the same edge.
      if (wr_en && ({1'b0, wr_addr} < NW)) shadow[wr_addr] <= wr_data;
      unique case (state)
        RUN:   if (commit) state <= DRAIN;
        DRAIN: if (cnt_nxt == 3'd0) state <= SWAP;
        SWAP: begin
          active      <= shadow;
          state       <= RUN;
          commit_done <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Testbench for iir_coef_ctrl.
//
// The bench plays upstream source, iir_core (a FIFO of limited depth with
// random ready/valid behaviour) and downstream sink. When the source hands a
// sample over, the scoreboard records the sample and the coefficient bank the
// reference model says must be live at that moment. When the emulated core
// retires a sample, the monitor compares the data and the coefficients that
// were on coefs when the core took the sample in.
//
// The reference model follows the commit rules directly:
//   - A commit accepted while idle blocks input from the next cycle on.
//   - The first cycle, from that point, that ends with the core empty is the
//     last drain cycle.
//   - The following cycle is the swap. The new bank and commit_done appear
//     one cycle after the swap.
module tb_iir_coef_ctrl;
  localparam int DW = 24, COEFW = 18, COEFQ = 16, ORDER = 2;
  localparam int N = (ORDER + 1) * 2, AW = $clog2(N);
  localparam int CORE_DEPTH = 4;

  typedef logic [N-1:0][COEFW-1:0] bank_t;
  typedef struct {
    logic [DW-1:0] data;
    bank_t         c;
  } item_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    s_axis_tdata;
  logic             s_axis_tvalid, s_axis_tready;
  logic [DW-1:0]    core_s_tdata;
  logic             core_s_tvalid, core_s_tready;
  logic             core_m_tvalid, core_m_tready;
  bank_t            coefs;
  logic             wr_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [COEFW-1:0] wr_data, rd_data;
  logic             commit, busy, commit_done;

  always #5 clk = ~clk;

  iir_coef_ctrl #(.DW(DW), .COEFW(COEFW), .COEFQ(COEFQ), .ORDER(ORDER)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .core_s_tdata(core_s_tdata), .core_s_tvalid(core_s_tvalid), .core_s_tready(core_s_tready),
    .core_m_tvalid(core_m_tvalid), .core_m_tready(core_m_tready),
    .coefs(coefs), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .commit(commit), .busy(busy),
    .commit_done(commit_done)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model state.
  bank_t       m_shadow, m_active;
  bit          m_pend = 0, checking = 0;
  int          drain_from = 0, swap_at = -1, done_at = -1;
  item_t       core_q[$], sb[$], out_q[$];
  logic [DW-1:0] ramp = 1;

  // Traffic knobs used by step().
  bit src_en = 0, src_rand = 0, m_en = 1, m_rand = 0, c_rand = 0;

  function automatic bank_t ident();
    bank_t b = '0;
    b[0] = COEFW'(1) << COEFQ;
    return b;
  endfunction

  // Model, emulated core and scoreboard producer, evaluated mid-cycle.
  initial begin
    item_t it;
    bit    was_pend;
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("coefs", coefs, m_active);
        chk("busy", busy, m_pend);
        chk("commit_done", commit_done, cyc == done_at);
        chk("s_tready", s_axis_tready, m_pend ? 1'b0 : core_s_tready);
        chk("core_tvalid", core_s_tvalid, m_pend ? 1'b0 : s_axis_tvalid);
        if (rd_addr < N) chk("rd_data", rd_data, m_active[rd_addr]);
        else             chk("rd_data_oob", rd_data, 0);
        if (!m_pend && s_axis_tvalid) chk("core_tdata", core_s_tdata, s_axis_tdata);
      end
      if (rst) begin
        m_shadow = ident(); m_active = ident();
        m_pend = 0; swap_at = -1; done_at = -1; checking = 1;
        core_q.delete(); sb.delete(); out_q.delete();
      end else begin
        if (s_axis_tvalid && s_axis_tready) begin
          it.data = s_axis_tdata; it.c = m_active;
          sb.push_back(it);
          ramp++;
        end
        if (core_s_tvalid && core_s_tready) begin
          it.data = core_s_tdata; it.c = coefs;
          core_q.push_back(it);
        end
        if (core_m_tvalid && core_m_tready) begin
          chk("no_underflow", core_q.size() > 0, 1);
          if (core_q.size() > 0) out_q.push_back(core_q.pop_front());
        end
        was_pend = m_pend;
        if (m_pend && cyc == swap_at) begin
          m_active = m_shadow;
          m_pend = 0; swap_at = -1; done_at = cyc + 1;
        end else if (m_pend && swap_at < 0 && cyc >= drain_from && core_q.size() == 0) begin
          swap_at = cyc + 1;
        end
        if (wr_en && wr_addr < N) m_shadow[wr_addr] = wr_data;
        if (!was_pend && commit) begin
          m_pend = 1; drain_from = cyc + 1; swap_at = -1;
        end
      end
    end
  end

  // Monitor: every sample the core retires must match the scoreboard head.
  initial begin
    item_t got, e;
    forever begin
      @(posedge clk);
      while (out_q.size() > 0) begin
        got = out_q.pop_front();
        chk("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_data", got.data, e.data);
          chk("out_coefs", got.c, e.c);
        end
      end
    end
  end

  // Advance one cycle and drive that cycle's inputs. Single-cycle strobes
  // (commit, wr_en) drop here and may be raised by the caller afterwards.
  task automatic step();
    @(posedge clk); #1;
    commit = 0; wr_en = 0;
    wr_addr = AW'($urandom_range(0, 7)); wr_data = COEFW'($urandom);
    rd_addr = AW'($urandom_range(0, 7));
    s_axis_tvalid = src_en && (!src_rand || $urandom_range(0, 2) != 0);
    s_axis_tdata  = ramp;
    core_m_tvalid = core_q.size() > 0;
    core_m_tready = m_en && (!m_rand || $urandom_range(0, 2) != 0);
    core_s_tready = (core_q.size() < CORE_DEPTH) && (!c_rand || $urandom_range(0, 3) != 0);
  endtask

  bit hit = 0;
  task automatic run_until_done(input int lim, input bit swap_wr, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < lim; i++) begin
      step();
      if (swap_wr && cyc == swap_at) begin
        wr_en = 1; wr_addr = 2; wr_data = 999; hit = 1;
      end
      @(negedge clk);
      if (commit_done) begin dcyc = cyc; break; end
    end
    chk("done_seen", dcyc >= 0, 1);
  endtask

  task automatic count_done(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      @(negedge clk);
      if (commit_done) cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bank_t exp_b;
    int t, d, cnt;
    rst = 1; commit = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    s_axis_tvalid = 0; s_axis_tdata = 0; core_s_tready = 1;
    core_m_tvalid = 0; core_m_tready = 0;
    step(); rst = 1;
    step(); rst = 0;
    // Reset state.
    rd_addr = 0;
    @(negedge clk);
    chk("rst_coefs", coefs, {72'd0, 18'd0, 18'd65536});
    chk("rst_rd0", rd_data, 65536);
    chk("rst_busy", busy, 0);
    chk("rst_tready", s_axis_tready, core_s_tready);

    // Idle commit: latency 3, new bank visible with the done pulse.
    step(); wr_en = 1; wr_addr = 0; wr_data = 32768;
    for (int i = 1; i < N; i++) begin
      step(); wr_en = 1; wr_addr = AW'(i); wr_data = COEFW'(i * 100);
    end
    step(); commit = 1; t = cyc;
    step(); @(negedge clk); chk("idle_busy1", busy, 1);
    step(); @(negedge clk); chk("idle_busy2", busy, 1);
    run_until_done(20, 0, d);
    chk("idle_latency", d - t, 3);
    exp_b = '0; exp_b[0] = 32768;
    for (int i = 1; i < N; i++) exp_b[i] = COEFW'(i * 100);
    chk("idle_coefs", coefs, exp_b);

    // Commit under load: downstream stalled, swap waits for the core to empty.
    src_en = 1; m_en = 0;
    repeat (8) step();
    step(); wr_en = 1; wr_addr = 3; wr_data = 12345;
    step(); commit = 1;
    repeat (10) step();
    @(negedge clk);
    chk("load_busy", busy, 1);
    chk("load_stall", s_axis_tready, 0);
    chk("load_hold_coefs", coefs, exp_b);
    m_en = 1;
    run_until_done(200, 0, d);
    exp_b[3] = 12345;
    chk("load_new_coefs", coefs, exp_b);

    // Out-of-range write is dropped. A write during SWAP reaches shadow only.
    step(); wr_en = 1; wr_addr = 7; wr_data = 5555;
    step(); commit = 1;
    hit = 0;
    run_until_done(200, 1, d);
    rd_addr = 2; #1;
    chk("swap_wr_hit", hit, 1);
    chk("swap_wr_old", rd_data, 200);
    chk("oob_write_ignored", coefs, exp_b);
    step(); commit = 1;
    run_until_done(200, 0, d);
    rd_addr = 2; #1;
    chk("second_commit_999", rd_data, 999);

    // A second commit during DRAIN is ignored: exactly one pulse.
    m_en = 0;
    repeat (6) step();
    step(); commit = 1;
    step(); commit = 1;
    repeat (4) step();
    m_en = 1;
    count_done(40, cnt);
    chk("one_done_pulse", cnt, 1);
    chk("back_to_run", busy, 0);

    // Reset in the middle of a drain aborts the commit.
    m_en = 0;
    repeat (6) step();
    step(); commit = 1;
    repeat (3) step();
    @(negedge clk);
    chk("drain_before_rst", busy, 1);
    src_en = 0;
    step(); rst = 1;
    step(); rst = 0; m_en = 1;
    @(negedge clk);
    chk("rst_abort_busy", busy, 0);
    chk("rst_abort_coefs", coefs, ident());
    count_done(10, cnt);
    chk("rst_no_done", cnt, 0);
    step(); commit = 1; t = cyc;
    run_until_done(20, 0, d);
    chk("post_rst_latency", d - t, 3);

    // Random traffic, writes and commits.
    src_en = 1; src_rand = 1; m_rand = 1; c_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) m_en = ($urandom_range(0, 3) != 0);
      step();
      if ($urandom_range(0, 9) == 0) begin
        wr_en = 1; wr_addr = AW'($urandom_range(0, 7)); wr_data = COEFW'($urandom);
      end
      if ($urandom_range(0, 29) == 0) commit = 1;
    end

    // Drain everything and confirm nothing was lost.
    src_en = 0; m_en = 1; m_rand = 0;
    for (int i = 0; i < 100 && (core_q.size() > 0 || busy); i++) step();
    step(); step();
    @(negedge clk);
    chk("final_idle", busy, 0);
    chk("final_core_empty", core_q.size(), 0);
    chk("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_coef_ctrl.md
Name: iir_coef_ctrl

Overview:
- Coefficient controller for one iir_core instance.
- Holds a shadow coefficient bank, written one word at a time from a config port, and an active bank that drives the core's coefs input.
- On commit, it stalls the input stream, drains every sample in flight through the core, then copies shadow into active in one cycle. No sample is ever computed with a mixed coefficient set.
- Sits between the upstream AXI-stream source and iir_core, and taps the core's output handshake.

Parameters:
- DW, 24, sample width.
- COEFW, 18, coefficient width, signed fixed point.
- COEFQ, 16, coefficient fraction bits.
- ORDER, 2, filter order. Localparam N = (ORDER+1)*2 coefficients; AW = $clog2(N).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  DW  signed upstream sample
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  upstream ready
- core_s_tdata  out  DW  to iir_core s_axis_tdata
- core_s_tvalid  out  1  to iir_core s_axis_tvalid
- core_s_tready  in  1  from iir_core s_axis_tready
- core_m_tvalid  in  1  tap of iir_core m_axis_tvalid
- core_m_tready  in  1  tap of iir_core m_axis_tready
- coefs  out  COEFW x [N]  active bank, to iir_core coefs
- wr_en  in  1  shadow write strobe
- wr_addr  in  AW  shadow index
- wr_data  in  COEFW  shadow data
- rd_addr  in  AW  active-bank readback index
- rd_data  out  COEFW  active[rd_addr], combinational; 0 if rd_addr >= N
- commit  in  1  single-cycle commit request
- busy  out  1  high in DRAIN or SWAP
- commit_done  out  1  one-cycle pulse when the new bank is live

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - Both banks = identity: index 0 = 1<<COEFQ, all other indices 0.
  - State = RUN, outstanding = 0, commit_done = 0.
  - Reset mid-DRAIN or mid-SWAP aborts the commit; no commit_done pulse follows.
- Shadow write:
  - On wr_en with wr_addr < N, shadow[wr_addr] <= wr_data.
  - Writes with wr_addr >= N are ignored.
  - Writes are accepted in every state.
  - A write in the SWAP cycle: active receives the old shadow value; shadow then holds the new value.
- Outstanding counter (3 bits):
  - +1 on a core input handshake (core_s_tvalid && core_s_tready).
  - −1 on a core output handshake (core_m_tvalid && core_m_tready).
  - Both in the same cycle: unchanged.
  - Never underflows in legal use; the bench asserts this.
- RUN state:
  - core_s_tdata = s_axis_tdata, core_s_tvalid = s_axis_tvalid, s_axis_tready = core_s_tready.
  - busy = 0.
  - commit high -> DRAIN at the next edge. A handshake in the commit cycle still completes and is counted.
- DRAIN state:
  - core_s_tvalid = 0 and s_axis_tready = 0; core_s_tdata is don't-care.
  - busy = 1.
  - Go to SWAP on the edge where outstanding == 0, taking same-cycle decrements into account (use the next-count value).
- SWAP state:
  - Input stays blocked, busy = 1. Lasts exactly one cycle.
  - active <= shadow (all N words) at the end of the cycle; next state = RUN.
  - commit_done is registered high for the first RUN cycle, i.e. the first cycle coefs shows the new values.
- commit while in DRAIN or SWAP is ignored; it is neither queued nor re-armed.
- Latency: with an idle core, commit at cycle t gives DRAIN at t+1, SWAP at t+2, new coefs and commit_done at t+3.
- coefs changes only at the end of SWAP or at reset.

Test Plan:
- Reset: assert rst for 2 cycles -> coefs = {65536, 0, 0, 0, 0, 0}; rd_data at addr 0 = 65536; busy = 0; s_axis_tready follows core_s_tready.
- Idle commit: write shadow[1..5] = 100..500, shadow[0] = 32768, pulse commit at t -> busy high t+1..t+2; at t+3 coefs = {32768, 100, 200, 300, 400, 500} and commit_done high for exactly 1 cycle.
- Commit under load: stream a continuous ramp 1, 2, 3… with m_axis_tready held low, commit -> s_axis_tready low while busy; coefs unchanged until downstream drains every accepted sample; swap then occurs; no samples lost or duplicated; the sample after the swap is filtered with new coefficients only.
- Write edge cases: wr_addr = 7 with N = 6 -> no change anywhere; a write to shadow[2] = 999 in the SWAP cycle -> active[2] gets the old shadow value; a second commit makes active[2] = 999.
- Ignored commit: pulse commit again during DRAIN -> exactly one commit_done pulse; state returns to RUN.
- Reset mid-DRAIN: commit, hold m_axis_tready low, assert rst -> identity coefs, busy = 0, no commit_done pulse afterwards, outstanding = 0.
